// File: rtl/jpeg_seq_pkg.sv
// Shared types for the JPEG stream sequencer: FSM states, channel IDs,
// the FIFO entry layout and the MCU-order state advance helper.
package jpeg_seq_pkg;

    typedef enum logic [1:0] {
        S_Y  = 2'd0,
        S_CB = 2'd1,
        S_CR = 2'd2
    } seq_state_t;

    localparam logic [1:0] CH_Y  = 2'd0;
    localparam logic [1:0] CH_CB = 2'd1;
    localparam logic [1:0] CH_CR = 2'd2;

    localparam int NUM_CH = 3;

    // One buffered word: block-end flag, valid-bit count of a final word, payload.
    typedef struct packed {
        logic        last;
        logic [4:0]  orc;
        logic [31:0] data;
    } seq_entry_t;

    // MCU order is Y -> Cb -> Cr -> Y; anything unexpected restarts at Y.
    function automatic seq_state_t nextState(input seq_state_t s);
        case (s)
            S_Y:     return S_CB;
            S_CB:    return S_CR;
            default: return S_Y;
        endcase
    endfunction

endpackage

// File: rtl/seq_chan_fifo.sv
// Per-channel synchronous FIFO for the JPEG stream sequencer.
// A push into a full FIFO is only accepted when a pop happens in the same
// cycle; otherwise the word is dropped and ovfPulse is raised for one cycle.
module seq_chan_fifo
    import jpeg_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  seq_entry_t wrEntry,
    input  logic       pop,
    output seq_entry_t rdEntry,
    output logic       full,
    output logic       empty,
    output logic       ovfPulse
);

    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    seq_entry_t    r_mem [DEPTH];

    logic w_clear;
    logic w_accept;
    logic w_doPop;

    assign w_clear  = rst || flush;
    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_doPop  = pop && !empty;
    assign w_accept = push && (!full || w_doPop);
    assign ovfPulse = push && full && !w_doPop;
    assign rdEntry  = r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_accept, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_accept && !w_clear) begin
            r_mem[r_wrPtr] <= wrEntry;
        end
    end

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Merges the Y, Cb and Cr Huffman bitstreams into one 32-bit word stream in
// MCU order (one Y block, one Cb block, one Cr block, repeating). Each channel
// is buffered in its own FIFO; an empty current channel stalls the stream.
// Optional feature macro: JPEG_SEQ_MCU_CNT_EN adds a 16-bit MCU counter port.
module jpeg_stream_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] y_data,
    input  logic        y_valid,
    input  logic        y_last,
    input  logic [4:0]  y_orc,
    input  logic [31:0] cb_data,
    input  logic        cb_valid,
    input  logic        cb_last,
    input  logic [4:0]  cb_orc,
    input  logic [31:0] cr_data,
    input  logic        cr_valid,
    input  logic        cr_last,
    input  logic [4:0]  cr_orc,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [4:0]  out_orc,
    output logic [1:0]  out_chan,
    output logic [2:0]  ovf
`ifdef JPEG_SEQ_MCU_CNT_EN
    ,
    output logic [15:0] mcu_count
`endif
);

    seq_state_t  r_state;
    logic [31:0] r_outData;
    logic        r_outValid;
    logic        r_outLast;
    logic [4:0]  r_outOrc;
    logic [1:0]  r_outChan;
    logic [2:0]  r_ovf;

    seq_entry_t  w_wrEntry  [NUM_CH];
    seq_entry_t  w_rdEntry  [NUM_CH];
    logic [2:0]  w_push;
    logic [2:0]  w_pop;
    logic [2:0]  w_full;
    logic [2:0]  w_empty;
    logic [2:0]  w_ovfPulse;
    logic        w_unusedFull;

    seq_entry_t  w_sel;
    logic [1:0]  w_selChan;
    logic        w_selAvail;
    logic        w_load;

    assign w_wrEntry[0] = {y_last, y_orc, y_data};
    assign w_wrEntry[1] = {cb_last, cb_orc, cb_data};
    assign w_wrEntry[2] = {cr_last, cr_orc, cr_data};
    assign w_push       = {cr_valid, cb_valid, y_valid};

    // Full flags are kept for debug visibility; overflow comes from the FIFO pulse.
    assign w_unusedFull = ^w_full;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        seq_chan_fifo #(
            .DEPTH (FIFO_DEPTH),
            .AW    (FIFO_AW)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (w_push[g]),
            .wrEntry  (w_wrEntry[g]),
            .pop      (w_pop[g]),
            .rdEntry  (w_rdEntry[g]),
            .full     (w_full[g]),
            .empty    (w_empty[g]),
            .ovfPulse (w_ovfPulse[g])
        );
    end

    // Pick the head entry of the FIFO belonging to the channel the FSM is serving.
    always_comb begin
        w_sel      = '0;
        w_selChan  = CH_Y;
        w_selAvail = 1'b0;
        case (r_state)
            S_Y: begin
                w_sel      = w_rdEntry[0];
                w_selChan  = CH_Y;
                w_selAvail = !w_empty[0];
            end
            S_CB: begin
                w_sel      = w_rdEntry[1];
                w_selChan  = CH_CB;
                w_selAvail = !w_empty[1];
            end
            S_CR: begin
                w_sel      = w_rdEntry[2];
                w_selChan  = CH_CR;
                w_selAvail = !w_empty[2];
            end
            default: begin
                w_sel      = '0;
                w_selChan  = CH_Y;
                w_selAvail = 1'b0;
            end
        endcase
    end

    assign w_load = (!r_outValid || out_ready) && w_selAvail;
    assign w_pop  = w_load ? (3'b001 << w_selChan) : 3'b000;

    // FSM, output register and sticky overflow flags; rst/flush clear everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state    <= S_Y;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outOrc   <= '0;
            r_outChan  <= '0;
            r_ovf      <= '0;
        end else begin
            r_ovf <= r_ovf | w_ovfPulse;
            if (w_load) begin
                r_outValid <= 1'b1;
                r_outData  <= w_sel.data;
                r_outLast  <= w_sel.last;
                r_outOrc   <= w_sel.last ? w_sel.orc : 5'd0;
                r_outChan  <= w_selChan;
                if (w_sel.last) begin
                    r_state <= nextState(r_state);
                end
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

`ifdef JPEG_SEQ_MCU_CNT_EN
    logic [15:0] r_mcuCount;

    // Count completed MCUs: each time the Cr block's final word is popped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_mcuCount <= '0;
        end else if (w_load && w_sel.last && (r_state == S_CR)) begin
            r_mcuCount <= r_mcuCount + 16'd1;
        end
    end

    assign mcu_count = r_mcuCount;
`endif

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign out_orc   = r_outOrc;
    assign out_chan  = r_outChan;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Self-checking bench for jpeg_stream_sequencer. A transaction-level model
// keeps one queue per channel plus the channel whose block is expected next;
// every word accepted downstream is checked against the head of that queue.
// Build with +define+JPEG_SEQ_MCU_CNT_EN to also exercise the MCU counter.
module tb_jpeg_stream_sequencer;
    import jpeg_seq_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] y_data = '0, cb_data = '0, cr_data = '0;
    logic        y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
    logic        y_last = 1'b0, cb_last = 1'b0, cr_last = 1'b0;
    logic [4:0]  y_orc = '0, cb_orc = '0, cr_orc = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [4:0]  out_orc;
    logic [1:0]  out_chan;
    logic [2:0]  ovf;
`ifdef JPEG_SEQ_MCU_CNT_EN
    logic [15:0] mcu_count;
`endif

    int testCount = 0;
    int failCount = 0;
    int acceptedCount = 0;

    seq_entry_t  modelQ [3][$];
    int          modelChan = 0;
    logic [2:0]  modelOvf = '0;
    logic        obsValid;
    logic [31:0] obsData;

    jpeg_stream_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_last    (y_last),
        .y_orc     (y_orc),
        .cb_data   (cb_data),
        .cb_valid  (cb_valid),
        .cb_last   (cb_last),
        .cb_orc    (cb_orc),
        .cr_data   (cr_data),
        .cr_valid  (cr_valid),
        .cr_last   (cr_last),
        .cr_orc    (cr_orc),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_orc   (out_orc),
        .out_chan  (out_chan),
        .ovf       (ovf)
`ifdef JPEG_SEQ_MCU_CNT_EN
        ,
        .mcu_count (mcu_count)
`endif
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic seq_entry_t mkEntry(input logic [31:0] d, input logic l,
                                           input logic [4:0] o);
        seq_entry_t e;
        e.data = d;
        e.last = l;
        e.orc  = o;
        return e;
    endfunction

    function automatic int queuedTotal();
        return modelQ[0].size() + modelQ[1].size() + modelQ[2].size();
    endfunction

    // Words the model says could still be delivered in MCU order from what is queued.
    function automatic int countDeliverable();
        int idx [3];
        int ch;
        int cnt;
        idx[0] = 0; idx[1] = 0; idx[2] = 0;
        ch  = modelChan;
        cnt = 0;
        while (idx[ch] < modelQ[ch].size()) begin
            cnt++;
            idx[ch]++;
            if (modelQ[ch][idx[ch]-1].last) ch = (ch + 1) % 3;
        end
        return cnt;
    endfunction

    // The word currently presented is taken at the coming edge: compare it to the model.
    task automatic checkAccepted();
        seq_entry_t exp;
        if (modelQ[modelChan].size() == 0) begin
            checkOutput("extra_word", 32'(out_valid), 32'd0);
        end else begin
            exp = modelQ[modelChan].pop_front();
            checkOutput("out_data", out_data, exp.data);
            checkOutput("out_last", 32'(out_last), 32'(exp.last));
            checkOutput("out_orc",  32'(out_orc), exp.last ? 32'(exp.orc) : 32'd0);
            checkOutput("out_chan", 32'(out_chan), 32'(modelChan));
            acceptedCount++;
            if (exp.last) modelChan = (modelChan + 1) % 3;
        end
    endtask

    // One cycle: sample at the falling edge, update the model, drive new inputs.
    task automatic applyStimulus(input logic [2:0] v, input seq_entry_t ey,
                                 input seq_entry_t ecb, input seq_entry_t ecr,
                                 input logic rdy);
        seq_entry_t e [3];
        @(negedge clk);
        obsValid = out_valid;
        obsData  = out_data;
        e[0] = ey; e[1] = ecb; e[2] = ecr;
        for (int c = 0; c < 3; c++) begin
            if (v[c]) begin
                if (modelQ[c].size() < DEPTH) modelQ[c].push_back(e[c]);
                else modelOvf[c] = 1'b1;
            end
        end
        if (out_valid && rdy) checkAccepted();
        out_ready = rdy;
        y_valid  = v[0]; y_data  = ey.data;  y_last  = ey.last;  y_orc  = ey.orc;
        cb_valid = v[1]; cb_data = ecb.data; cb_last = ecb.last; cb_orc = ecb.orc;
        cr_valid = v[2]; cr_data = ecr.data; cr_last = ecr.last; cr_orc = ecr.orc;
    endtask

    task automatic sendWord(input int ch, input seq_entry_t e, input logic rdy);
        applyStimulus(3'(1 << ch), e, e, e, rdy);
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        repeat (n) applyStimulus(3'b000, '0, '0, '0, rdy);
    endtask

    // Pulse rst or flush for one edge and clear the model to match.
    task automatic applyReset(input logic viaFlush);
        @(negedge clk);
        out_ready = 1'b0;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        if (viaFlush) flush = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) modelQ[c].delete();
        modelChan = 0;
        modelOvf  = '0;
    endtask

    initial begin
        int base;
        logic [2:0] v;
        seq_entry_t re [3];

        // Reset state
        repeat (2) @(negedge clk);
        applyReset(1'b0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data",  out_data, 32'd0);
        checkOutput("rst_last",  32'(out_last), 32'd0);
        checkOutput("rst_orc",   32'(out_orc), 32'd0);
        checkOutput("rst_chan",  32'(out_chan), 32'd0);
        checkOutput("rst_ovf",   32'(ovf), 32'd0);

        // One full MCU, 3 words per channel, with first-word latency check
        base = acceptedCount;
        sendWord(0, mkEntry(32'hA000_0001, 1'b0, 5'd3), 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("latency_one_edge", 32'(obsValid), 32'd0);
        idleCycles(1, 1'b1);
        checkOutput("latency_two_edges", 32'(obsValid), 32'd1);
        sendWord(0, mkEntry(32'hA000_0002, 1'b0, 5'd7), 1'b1);
        sendWord(0, mkEntry(32'hA000_0003, 1'b1, 5'd12), 1'b1);
        for (int k = 0; k < 3; k++)
            sendWord(1, mkEntry(32'hB000_0000 + 32'(k), k == 2, 5'd12), 1'b1);
        for (int k = 0; k < 3; k++)
            sendWord(2, mkEntry(32'hC000_0000 + 32'(k), k == 2, 5'd12), 1'b1);
        idleCycles(6, 1'b1);
        checkOutput("mcu1_words", 32'(acceptedCount - base), 32'd9);

        // Cr and Cb arrive before Y: nothing may come out until Y arrives
        base = acceptedCount;
        for (int k = 0; k < 3; k++)
            sendWord(2, mkEntry(32'h3300_0000 + 32'(k), k == 2, 5'd9), 1'b1);
        for (int k = 0; k < 3; k++)
            sendWord(1, mkEntry(32'h2200_0000 + 32'(k), k == 2, 5'd0), 1'b1);
        idleCycles(4, 1'b1);
        checkOutput("stall_no_y", 32'(obsValid), 32'd0);
        for (int k = 0; k < 3; k++)
            sendWord(0, mkEntry(32'h1100_0000 + 32'(k), k == 2, 5'd31), 1'b1);
        idleCycles(12, 1'b1);
        checkOutput("reorder_words", 32'(acceptedCount - base), 32'd9);
        checkOutput("reorder_drained", 32'(queuedTotal()), 32'd0);

        // Output held while downstream stalls, then one word per cycle
        sendWord(0, mkEntry(32'hDEAD_BEEF, 1'b0, 5'd1), 1'b0);
        sendWord(0, mkEntry(32'h1111_1111, 1'b0, 5'd2), 1'b0);
        sendWord(0, mkEntry(32'h2222_2222, 1'b1, 5'd0), 1'b0);
        for (int k = 0; k < 10; k++) begin
            idleCycles(1, 1'b0);
            checkOutput("hold_valid", 32'(obsValid), 32'd1);
            checkOutput("hold_data", obsData, 32'hDEAD_BEEF);
        end
        base = acceptedCount;
        idleCycles(3, 1'b1);
        checkOutput("release_rate", 32'(acceptedCount - base), 32'd3);
        sendWord(1, mkEntry(32'h4444_4444, 1'b1, 5'd4), 1'b1);
        sendWord(2, mkEntry(32'h5555_5555, 1'b1, 5'd5), 1'b1);
        idleCycles(5, 1'b1);
        checkOutput("hold_drained", 32'(queuedTotal()), 32'd0);

        // Cb overflow: 10 pushes into a depth-8 FIFO that is not being drained
        applyReset(1'b0);
        for (int k = 0; k < 10; k++)
            sendWord(1, mkEntry(32'hCB00_0000 + 32'(k), k == 7, 5'd3), 1'b0);
        idleCycles(2, 1'b0);
        checkOutput("ovf_set", 32'(ovf), 32'h2);
        checkOutput("ovf_model", 32'(ovf), 32'(modelOvf));
        base = acceptedCount;
        sendWord(0, mkEntry(32'h0A0A_0001, 1'b0, 5'd0), 1'b1);
        sendWord(0, mkEntry(32'h0A0A_0002, 1'b1, 5'd20), 1'b1);
        idleCycles(14, 1'b1);
        sendWord(2, mkEntry(32'h0C0C_0001, 1'b1, 5'd8), 1'b1);
        idleCycles(4, 1'b1);
        checkOutput("ovf_retained", 32'(acceptedCount - base), 32'd11);
        checkOutput("ovf_sticky", 32'(ovf), 32'h2);
        checkOutput("ovf_drained", 32'(queuedTotal()), 32'd0);
        applyReset(1'b1);
        checkOutput("flush_ovf", 32'(ovf), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a Cb block
        sendWord(0, mkEntry(32'h7000_0001, 1'b0, 5'd0), 1'b1);
        sendWord(0, mkEntry(32'h7000_0002, 1'b1, 5'd6), 1'b1);
        sendWord(1, mkEntry(32'h7100_0001, 1'b0, 5'd0), 1'b1);
        idleCycles(4, 1'b1);
        sendWord(1, mkEntry(32'h7100_0002, 1'b0, 5'd0), 1'b0);
        idleCycles(3, 1'b0);
        checkOutput("midblk_valid_before", 32'(obsValid), 32'd1);
        applyReset(1'b0);
        checkOutput("midblk_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("midblk_rst_ovf", 32'(ovf), 32'd0);
        checkOutput("midblk_rst_last", 32'(out_last), 32'd0);
        base = acceptedCount;
        sendWord(0, mkEntry(32'h7200_0001, 1'b1, 5'd10), 1'b1);
        sendWord(1, mkEntry(32'h7300_0001, 1'b1, 5'd11), 1'b1);
        sendWord(2, mkEntry(32'h7400_0001, 1'b1, 5'd13), 1'b1);
        idleCycles(6, 1'b1);
        checkOutput("midblk_after_words", 32'(acceptedCount - base), 32'd3);

        // Randomized traffic with random downstream backpressure, no overflow
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 3; c++) begin
                v[c]  = ($urandom_range(0, 2) == 0) && (modelQ[c].size() < DEPTH);
                re[c] = mkEntry($urandom, $urandom_range(0, 3) == 0,
                                5'($urandom_range(0, 31)));
            end
            applyStimulus(v, re[0], re[1], re[2], $urandom_range(0, 3) != 0);
        end
        idleCycles(60, 1'b1);
        checkOutput("rand_leftover", 32'(countDeliverable()), 32'd0);
        checkOutput("rand_ovf", 32'(ovf), 32'd0);

`ifdef JPEG_SEQ_MCU_CNT_EN
        // MCU counter: three complete MCUs, then flush
        applyReset(1'b0);
        for (int m = 0; m < 3; m++) begin
            sendWord(0, mkEntry(32'h9000_0000 + 32'(m), 1'b1, 5'd1), 1'b1);
            sendWord(1, mkEntry(32'h9100_0000 + 32'(m), 1'b1, 5'd2), 1'b1);
            sendWord(2, mkEntry(32'h9200_0000 + 32'(m), 1'b1, 5'd3), 1'b1);
        end
        idleCycles(6, 1'b1);
        checkOutput("mcu_count", 32'(mcu_count), 32'd3);
        applyReset(1'b1);
        checkOutput("mcu_count_flush", 32'(mcu_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
